// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue for the jt900h core.
// Fetches little-endian 16-bit words from RAM ahead of the program counter,
// keeps them in a circular byte queue, and presents the oldest four bytes
// to the decoder. A flush restarts fetching at any byte address, odd included.
//
// RAM handshake: ram_cs is a registered request that stays high with
// ram_addr stable until a cen edge samples ram_ok=1. That edge captures
// ram_dout and completes the transfer. Dropping ram_cs without ram_ok, as
// happens on a flush, abandons the request.
module jt900h_prefetch #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        flush,
    input  logic [23:0] flush_addr,
    input  logic [2:0]  fetched,
    output logic [23:0] ram_addr,
    output logic        ram_cs,
    input  logic [15:0] ram_dout,
    input  logic        ram_ok,
    output logic [31:0] op,
    output logic [3:0]  avail,
    output logic        op_ok,
    output logic [23:0] pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd, wr;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [23:0]     faddr, faddr_nx;
    logic [CW-1:0]   deq;
    logic [1:0]      enq;
    logic            cap;
    logic [CW-1:0]   space_now, space_nx;
    logic            room_now, room_nx;

    assign ram_addr = {faddr[23:1], 1'b0};
    assign ram_cs   = (state == REQ);
    assign avail    = 4'(cnt);
    assign op_ok    = (cnt >= CW'(4));

    // Next-state, consume clamp and fill accounting.
    always_comb begin
        deq       = (CW'(fetched) > cnt) ? cnt : CW'(fetched);
        cap       = (state == REQ) && ram_ok;
        enq       = 2'd0;
        if (cap) enq = faddr[0] ? 2'd1 : 2'd2;
        cnt_nx    = cnt + CW'(enq) - deq;
        faddr_nx  = faddr + 24'(enq);
        space_now = DEPTH_C - cnt;
        space_nx  = DEPTH_C - cnt_nx;
        // An odd fetch address only needs room for the upper byte.
        room_now  = faddr[0]    ? (space_now >= CW'(1)) : (space_now >= CW'(2));
        room_nx   = faddr_nx[0] ? (space_nx  >= CW'(1)) : (space_nx  >= CW'(2));
        state_nx  = state;
        case (state)
            IDLE: if (room_now) state_nx = REQ;
            REQ:  if (cap) state_nx = room_nx ? REQ : IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // State, pointers, counters and addresses; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd    <= '0;
            wr    <= '0;
            cnt   <= '0;
            pc    <= '0;
            faddr <= '0;
        end else if (cen) begin
            state <= state_nx;
            if (flush) begin
                rd    <= '0;
                wr    <= '0;
                cnt   <= '0;
                pc    <= flush_addr;
                faddr <= flush_addr;
            end else begin
                rd    <= rd + AW'(deq);
                wr    <= wr + AW'(enq);
                pc    <= pc + 24'(deq);
                cnt   <= cnt_nx;
                faddr <= faddr_nx;
            end
        end
    end

    // Byte storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (cen && !flush && cap) begin
            if (faddr[0]) begin
                mem[wr] <= ram_dout[15:8];
            end else begin
                mem[wr]         <= ram_dout[7:0];
                mem[wr + AW'(1)] <= ram_dout[15:8];
            end
        end
    end

    // Head bytes, zeroed at and beyond the valid count.
    always_comb begin
        op = '0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < cnt) op[8*i +: 8] = mem[rd + AW'(i)];
        end
    end

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Bench for jt900h_prefetch: directed vectors plus a throttled random run
// checked against an address-ordered byte scoreboard.
module tb_jt900h_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        flush;
    logic [23:0] flush_addr;
    logic [2:0]  fetched;
    logic [23:0] ram_addr;
    logic        ram_cs;
    logic [15:0] ram_dout;
    logic        ram_ok;
    logic [31:0] op;
    logic [3:0]  avail;
    logic        op_ok;
    logic [23:0] pc;
    logic        ok_en;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [23:0] exp_pc;
    int          consumed;

    // Clock / RAM model: byte at address a holds a[7:0]; ok gated by ok_en.
    always #5 clk = ~clk;
    assign ram_dout = {ram_addr[7:0] + 8'd1, ram_addr[7:0]};
    assign ram_ok   = ram_cs & ok_en;

    jt900h_prefetch #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .flush      (flush),
        .flush_addr (flush_addr),
        .fetched    (fetched),
        .ram_addr   (ram_addr),
        .ram_cs     (ram_cs),
        .ram_dout   (ram_dout),
        .ram_ok     (ram_ok),
        .op         (op),
        .avail      (avail),
        .op_ok      (op_ok),
        .pc         (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1; flush = 1'b0; flush_addr = '0;
        fetched = '0; ok_en = 1'b1;
        #1;
        chk("rst_cs",    32'(ram_cs),   0);
        chk("rst_addr",  32'(ram_addr), 0);
        chk("rst_avail", 32'(avail),    0);
        chk("rst_opok",  32'(op_ok),    0);
        chk("rst_op",    op,            0);
        chk("rst_pc",    32'(pc),       0);
        tick(); tick();
        rst_n = 1'b1;

        // Fill from address 0 with no consumption.
        tick();
        chk("first_cs",   32'(ram_cs),   1);
        chk("first_addr", 32'(ram_addr), 0);
        chk("first_av",   32'(avail),    0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fill_avail", 32'(avail), 32'(2 * k));
        end
        chk("full_cs",   32'(ram_cs), 0);
        chk("full_op",   op,          32'h03020100);
        chk("full_pc",   32'(pc),     0);
        chk("full_opok", 32'(op_ok),  1);
        tick(); tick();
        chk("full_hold_cs", 32'(ram_cs), 0);
        chk("full_hold_av", 32'(avail),  8);

        // Consume 3 from full queue, then refill word 8.
        fetched = 3'd3;
        tick();
        fetched = 3'd0;
        chk("c3_pc",    32'(pc),    3);
        chk("c3_op",    op,         32'h06050403);
        chk("c3_avail", 32'(avail), 5);
        tick();
        chk("refill_cs",   32'(ram_cs),   1);
        chk("refill_addr", 32'(ram_addr), 8);
        tick();
        chk("refill_av", 32'(avail),  7);
        chk("refill_cs0", 32'(ram_cs), 0);
        chk("refill_op", op,          32'h06050403);

        // Leave a request outstanding, then flush to an odd address.
        fetched = 3'd4;
        tick();
        fetched = 3'd0; ok_en = 1'b0;
        chk("c4_pc", 32'(pc), 7);
        chk("c4_op", op,      32'h00090807);
        tick(); tick();
        chk("pend_cs",   32'(ram_cs),   1);
        chk("pend_addr", 32'(ram_addr), 32'h0A);
        flush = 1'b1; flush_addr = 24'h000101; ok_en = 1'b1; fetched = 3'd2;
        tick();
        flush = 1'b0; fetched = 3'd0;
        chk("fl_cs",    32'(ram_cs), 0);
        chk("fl_avail", 32'(avail),  0);
        chk("fl_pc",    32'(pc),     32'h101);
        chk("fl_op",    op,          0);
        tick();
        chk("fl_req_cs",   32'(ram_cs),   1);
        chk("fl_req_addr", 32'(ram_addr), 32'h100);
        tick();
        chk("odd_avail", 32'(avail),    1);
        chk("odd_op",    op,            32'h00000001);
        chk("odd_pc",    32'(pc),       32'h101);
        chk("odd_next",  32'(ram_addr), 32'h102);

        // Over-consume clamp, then capture on the same edge as a consume request.
        ok_en = 1'b0; fetched = 3'd4;
        tick();
        chk("clamp_av", 32'(avail), 0);
        chk("clamp_pc", 32'(pc),    32'h102);
        chk("clamp_op", op,         0);
        ok_en = 1'b1; fetched = 3'd2;
        tick();
        chk("sim_av", 32'(avail), 2);
        chk("sim_pc", 32'(pc),    32'h102);
        chk("sim_op", op,         32'h00000302);
        ok_en = 1'b0; fetched = 3'd2;
        tick();
        chk("drain_av", 32'(avail), 0);
        chk("drain_pc", 32'(pc),    32'h104);

        // Address wrap at the top of the 24-bit space.
        flush = 1'b1; flush_addr = 24'hFFFFFE; fetched = 3'd0;
        tick();
        flush = 1'b0; ok_en = 1'b1;
        chk("wr_pc0", 32'(pc), 32'hFFFFFE);
        tick();
        chk("wr_addr0", 32'(ram_addr), 32'hFFFFFE);
        chk("wr_cs0",   32'(ram_cs),   1);
        tick();
        chk("wr_addr1", 32'(ram_addr), 0);
        chk("wr_op1",   op,            32'h0000FFFE);
        fetched = 3'd2;
        tick();
        chk("wr_pc1",   32'(pc),       0);
        chk("wr_addr2", 32'(ram_addr), 2);
        chk("wr_op2",   op,            32'h00000100);
        tick();
        chk("wr_pc2", 32'(pc), 2);
        chk("wr_op3", op,      32'h00000302);

        // Clock enable low: nothing moves even with ram_ok and fetched active.
        cen = 1'b0;
        tick(); tick();
        chk("cen_pc",   32'(pc),       2);
        chk("cen_av",   32'(avail),    2);
        chk("cen_addr", 32'(ram_addr), 4);
        chk("cen_cs",   32'(ram_cs),   1);
        cen = 1'b1; fetched = 3'd0;

        // Throttled random run against an address-ordered scoreboard.
        flush = 1'b1; flush_addr = 24'h000013;
        tick();
        flush = 1'b0;
        exp_pc = 24'h000013;
        consumed = 0;
        for (int i = 0; i < 4096; i++) exp_q.push_back(8'(24'h000013 + 24'(i)));
        for (int c = 0; c < 3000; c++) begin
            int lim;
            chk("rnd_pc",   32'(pc),    32'(exp_pc));
            chk("rnd_opok", 32'(op_ok), 32'(avail >= 4));
            for (int k = 0; k < 4; k++) begin
                if (k >= int'(avail)) chk("rnd_mask", 32'(op[8*k +: 8]), 0);
            end
            cen   = (c % 3 == 0);
            ok_en = ($urandom_range(0, 2) != 0);
            lim   = (avail > 4) ? 4 : int'(avail);
            fetched = 3'($urandom_range(0, lim));
            if (cen) begin
                for (int k = 0; k < int'(fetched); k++) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_q_empty", 1, 0);
                    end else begin
                        chk("rnd_byte", 32'(op[8*k +: 8]), 32'(exp_q.pop_front()));
                    end
                end
                exp_pc   = exp_pc + 24'(fetched);
                consumed = consumed + int'(fetched);
            end
            tick();
        end
        chk("rnd_progress", 32'(consumed > 100), 1);

        // Asynchronous reset while a request is pending.
        cen = 1'b1; fetched = 3'd0; ok_en = 1'b0;
        flush = 1'b1; flush_addr = 24'h000040;
        tick();
        flush = 1'b0;
        tick();
        chk("pre_rst_cs", 32'(ram_cs), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs",   32'(ram_cs),   0);
        chk("arst_addr", 32'(ram_addr), 0);
        chk("arst_pc",   32'(pc),       0);
        chk("arst_av",   32'(avail),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
